// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants for the instruction fetch unit.
// No logic; imported by the fetch queue and the fetch unit top.
package if_pkg;

  localparam int          WORD_W           = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Generic synchronous FIFO with flush; head is registered storage, visible the cycle after push.
// Push on a full queue is accepted only together with a pop; pop on empty is ignored.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter int  CW      = $clog2(DEPTH + 1),
  parameter type entry_t = fetch_entry_t
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_dat,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, credit-limited in-order imem reads, queued valid/ready output to decode.
// One-cycle response-to-output latency; IF_RSP_BYPASS_EN adds a zero-cycle path when the queue is empty.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int          QUEUE_DEPTH     = 2,
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] new_pc_value
);

  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int ACW = $clog2(MAX_OUTSTANDING + 1);

  logic [WORD_W-1:0] pc;
  logic              run_q;
  logic [ACW-1:0]    drop_cnt;
  logic [QCW-1:0]    q_count;
  logic              q_full, q_empty, q_push, q_pop;
  fetch_entry_t      q_head, q_push_dat;
  logic [ACW-1:0]    af_count;
  logic              af_full, af_empty;
  logic [WORD_W-1:0] af_head;
  logic              req_fire, rsp_accept, rsp_keep, bypass;
  logic [31:0]       credit_used;
  logic [1:0]        unused_tgt_lsb;

  assign unused_tgt_lsb = branch_target[1:0];

  // Slots already promised: queued entries plus in-flight reads that will actually be kept.
  assign credit_used    = 32'(q_count) + 32'(af_count) - 32'(drop_cnt);
  assign imem_req_valid = run_q && !branch_taken && !af_full && !q_full
                          && (credit_used < 32'(QUEUE_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_accept = imem_rsp_valid && !af_empty;
  assign rsp_keep   = rsp_accept && !branch_taken && (drop_cnt == '0);

`ifdef IF_RSP_BYPASS_EN
  assign bypass = q_empty && id_ready && rsp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign q_push     = rsp_keep && !bypass;
  assign q_push_dat = fetch_entry_t'{instr: imem_rsp_data, npc: af_head};
  assign q_pop      = !q_empty && id_ready && !branch_taken;

  always_comb begin
    if_valid     = !q_empty;
    instruction  = q_empty ? NOP_INSTR : q_head.instr;
    new_pc_value = q_empty ? '0 : q_head.npc;
    if (bypass) begin
      if_valid     = 1'b1;
      instruction  = imem_rsp_data;
      new_pc_value = af_head;
    end
  end

  if_fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .CW      (QCW),
    .entry_t (fetch_entry_t)
  ) u_fetch_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .push_dat (q_push_dat),
    .pop      (q_pop),
    .flush    (branch_taken),
    .head_dat (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // In-flight tracker: holds fetch address + 4 per request; its occupancy is the outstanding count.
  if_fetch_queue #(
    .DEPTH   (MAX_OUTSTANDING),
    .CW      (ACW),
    .entry_t (logic [WORD_W-1:0])
  ) u_addr_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_fire),
    .push_dat (pc + PC_INC),
    .pop      (rsp_accept),
    .flush    (1'b0),
    .head_dat (af_head),
    .count    (af_count),
    .full     (af_full),
    .empty    (af_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      run_q    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      run_q <= 1'b1;
      if (branch_taken) begin
        pc       <= {branch_target[31:2], 2'b00};
        drop_cnt <= af_count - ACW'(rsp_accept);
      end else begin
        if (req_fire) pc <= pc + PC_INC;
        if (rsp_accept && (drop_cnt != '0)) drop_cnt <= drop_cnt - ACW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: imem model with programmable latency/ready, in-order scoreboard.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready, if_valid;
  logic [31:0] instruction, new_pc_value;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_npc_log[$];
  logic [31:0] pop_ins_log[$];
  int          cyc, lat, max_out, n_tests, n_fail, rmark, pmark;
  bit          toggle, mem_en, ok;
  logic [31:0] exp_npc;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .instruction    (instruction),
    .new_pc_value   (new_pc_value)
  );

  // Memory image: word n (address 4*(n-1)) encodes n in two register fields.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    logic [31:0] n;
    n = (a >> 2) + 32'd1;
    return (n << 21) | (n << 11) | 32'h20;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mem_drive();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_en && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_at(pend[0].addr);
      void'(pend.pop_front());
    end
    if (toggle) imem_req_ready = !imem_req_ready;
  endtask

  // Called at a negedge with this cycle's inputs driven; samples just before the posedge.
  task automatic cycle();
    int    out_now;
    pend_t e;
    #3;
    if (rst_n) begin
      out_now = pend.size() + (imem_rsp_valid ? 1 : 0);
      if (out_now > max_out) max_out = out_now;
      if (branch_taken) begin
        exp_npc = {branch_target[31:2], 2'b00} + 32'd4;
      end else if (if_valid && id_ready) begin
        pop_npc_log.push_back(new_pc_value);
        pop_ins_log.push_back(instruction);
        check("seq_npc", new_pc_value, exp_npc);
        check("seq_instr", instruction, instr_at(exp_npc - 32'd4));
        exp_npc = exp_npc + 32'd4;
      end
      if (imem_req_valid && imem_req_ready) begin
        e.addr = imem_req_addr;
        e.due  = cyc + lat;
        pend.push_back(e);
        req_log.push_back(imem_req_addr);
      end
    end
    @(negedge clk);
    cyc++;
    mem_drive();
  endtask

  task automatic wait_out2(input string tag);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (pend.size() == 2 && !imem_rsp_valid) ok = 1'b1;
      else cycle();
    end
    check(tag, ok, 1);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    rmark         = req_log.size();
    pmark         = pop_npc_log.size();
    branch_taken  = 1'b1;
    branch_target = tgt;
    #1;
    check("br_no_req", imem_req_valid, 0);
    cycle();
    branch_taken  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    branch_taken = 1'b0; branch_target = '0; id_ready = 1'b1;
    lat = 1; toggle = 1'b0; mem_en = 1'b1; exp_npc = 32'd4;
    cyc = 0; max_out = 0; n_tests = 0; n_fail = 0;

    #7;
    check("rst_if_valid", if_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr", instruction, 32'h0);
    check("rst_npc", new_pc_value, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_drive();

    // Free-running fetch, 1-cycle memory
    repeat (12) cycle();
    check("p1_addr0", qget(req_log, 0), 32'h0000_0000);
    check("p1_addr1", qget(req_log, 1), 32'h0000_0004);
    check("p1_addr2", qget(req_log, 2), 32'h0000_0008);
    check("p1_ins0", qget(pop_ins_log, 0), 32'h0020_0820);
    check("p1_ins1", qget(pop_ins_log, 1), 32'h0040_1020);
    check("p1_ins2", qget(pop_ins_log, 2), 32'h0060_1820);
    check("p1_npc0", qget(pop_npc_log, 0), 32'h0000_0004);
    check("p1_npc1", qget(pop_npc_log, 1), 32'h0000_0008);
    check("p1_npc2", qget(pop_npc_log, 2), 32'h0000_000C);

    // Decode stall: queue fills, requests stop, head holds
    id_ready = 1'b0;
    repeat (3) cycle();
    check("stall_valid", if_valid, 1);
    check("stall_instr", instruction, instr_at(exp_npc - 32'd4));
    repeat (7) cycle();
    check("stall_instr_hold", instruction, instr_at(exp_npc - 32'd4));
    check("stall_npc_hold", new_pc_value, exp_npc);
    check("stall_req_off", imem_req_valid, 0);
    pmark    = pop_npc_log.size();
    id_ready = 1'b1;
    repeat (10) cycle();
    check("drain_pops", (pop_npc_log.size() - pmark) >= 3, 1);

    // Redirect with two reads in flight
    lat = 3;
    wait_out2("wait_out2_br");
    redirect(32'h0000_0102);
    repeat (15) cycle();
    check("br_addr", qget(req_log, rmark), 32'h0000_0100);
    check("br_npc", qget(pop_npc_log, pmark), 32'h0000_0104);
    check("br_instr", qget(pop_ins_log, pmark), 32'h0822_0820);

    // Ready toggling, 2-cycle memory
    lat = 2; toggle = 1'b1;
    pmark = pop_npc_log.size();
    repeat (30) cycle();
    toggle = 1'b0; imem_req_ready = 1'b1;
    check("tog_pops", (pop_npc_log.size() - pmark) >= 4, 1);
    check("max_out_le2", max_out <= 2, 1);

    // PC wrap at the top of the address space
    lat = 1;
    redirect(32'hFFFF_FFFC);
    repeat (12) cycle();
    check("wrap_addr0", qget(req_log, rmark), 32'hFFFF_FFFC);
    check("wrap_addr1", qget(req_log, rmark + 1), 32'h0000_0000);
    check("wrap_npc0", qget(pop_npc_log, pmark), 32'h0000_0000);
    check("wrap_instr0", qget(pop_ins_log, pmark), 32'h0000_0020);
    check("wrap_npc1", qget(pop_npc_log, pmark + 1), 32'h0000_0004);

    // Reset mid-stream with two reads in flight; stale responses land after release
    lat = 3;
    wait_out2("wait_out2_rst");
    #2;
    rst_n = 1'b0; mem_en = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    check("rst2_if_valid", if_valid, 0);
    check("rst2_req_valid", imem_req_valid, 0);
    check("rst2_instr", instruction, 32'h0);
    check("rst2_npc", new_pc_value, 32'h0);
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1; mem_en = 1'b1; exp_npc = 32'd4;
    rmark = req_log.size();
    pmark = pop_npc_log.size();
    mem_drive();
    repeat (15) cycle();
    check("rst2_stale_gone", pend.size() <= 2, 1);
    check("rst2_addr0", qget(req_log, rmark), 32'h0000_0000);
    check("rst2_npc0", qget(pop_npc_log, pmark), 32'h0000_0004);
    check("rst2_instr0", qget(pop_ins_log, pmark), 32'h0020_0820);
    check("rst2_npc1", qget(pop_npc_log, pmark + 1), 32'h0000_0008);
    check("max_out_final", max_out <= 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
